// File: rtl/color_pkg.sv
// Shared types and constants for the color-detect frame scheduler.
// The result struct is the payload handed to the downstream tracker.
package color_pkg;

  localparam int PROF_W  = 2;
  localparam int ROW_W   = 13;
  localparam int COL_W   = 13;
  localparam int ROW_MAX = 477;
  localparam int COL_MAX = 617;
  localparam int CNT_W   = 19;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [PROF_W-1:0] prof;
    logic [CNT_W-1:0]  count;
    logic [ROW_W-1:0]  rmin;
    logic [ROW_W-1:0]  rmax;
    logic [COL_W-1:0]  cmin;
    logic [COL_W-1:0]  cmax;
    logic              empty;
  } result_t;

endpackage

// File: rtl/color_profile_sched_if.sv
// Pixel-side inputs, profile select and result handshake of the scheduler.
// master = upstream datapath plus downstream consumer, slave = scheduler.
interface color_profile_sched_if #(
  parameter int NPROF = 4,
  parameter int CNT_W = 19
);
  logic [NPROF-1:0] i_en_mask;
  logic             i_frame_start;
  logic             i_pix_valid;
  logic [12:0]      i_row;
  logic [12:0]      i_col;
  logic             i_hit;
  logic [1:0]       o_prof_sel;
  logic             o_busy;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [1:0]       o_res_prof;
  logic [CNT_W-1:0] o_res_count;
  logic [12:0]      o_res_rmin;
  logic [12:0]      o_res_rmax;
  logic [12:0]      o_res_cmin;
  logic [12:0]      o_res_cmax;
  logic             o_res_empty;
  logic             o_overrun;

  modport master (
    output i_en_mask, i_frame_start, i_pix_valid, i_row, i_col, i_hit, i_res_ready,
    input  o_prof_sel, o_busy, o_res_valid, o_res_prof, o_res_count,
           o_res_rmin, o_res_rmax, o_res_cmin, o_res_cmax, o_res_empty, o_overrun
  );

  modport slave (
    input  i_en_mask, i_frame_start, i_pix_valid, i_row, i_col, i_hit, i_res_ready,
    output o_prof_sel, o_busy, o_res_valid, o_res_prof, o_res_count,
           o_res_rmin, o_res_rmax, o_res_cmin, o_res_cmax, o_res_empty, o_overrun
  );
endinterface

// File: rtl/color_profile_sched_rr_pick.sv
// Combinational round-robin finder: first enabled slot strictly after 'last',
// wrapping at NPROF. 'any' is low when no slot is enabled.
module rr_pick
  import color_pkg::*;
#(
  parameter int NPROF = 4
) (
  input  logic [NPROF-1:0]  mask,
  input  logic [PROF_W-1:0] last,
  output logic [PROF_W-1:0] next,
  output logic              any
);

  logic [2*NPROF-1:0] dbl;
  logic [PROF_W:0]    shamt;
  logic [NPROF-1:0]   rot;
  logic [NPROF-1:0]   scan;
  logic [PROF_W-1:0]  off;
  logic [PROF_W:0]    sum;

  // Rotating the doubled mask puts slot last+1 at bit 0.
  assign dbl   = {mask, mask};
  assign shamt = {1'b0, last} + (PROF_W+1)'(1);
  assign rot   = NPROF'(dbl >> shamt);

  always_comb begin
    scan = rot;
    off  = '0;
    any  = 1'b0;
    for (int k = 0; k < NPROF; k++) begin
      if (!any && scan[0]) begin
        any = 1'b1;
        off = PROF_W'(k);
      end
      scan = scan >> 1;
    end
  end

  assign sum  = shamt + {1'b0, off};
  assign next = (sum >= (PROF_W+1)'(NPROF)) ? PROF_W'(sum - (PROF_W+1)'(NPROF))
                                             : PROF_W'(sum);

endmodule

// File: rtl/color_profile_sched.sv
// Frame-level round-robin scheduler for the shared HSV threshold comparator:
// counts hit pixels and their bounding box per frame, publishes one result per frame.
module color_profile_sched
  import color_pkg::*;
#(
  parameter int NPROF   = 4,
  parameter int ROW_MAX = color_pkg::ROW_MAX,
  parameter int COL_MAX = color_pkg::COL_MAX,
  parameter int CNT_W   = color_pkg::CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  color_profile_sched_if.slave bus
);

  state_t            state_reg, state_next;
  logic [PROF_W-1:0] prof_sel_reg, prof_sel_next;
  logic [PROF_W-1:0] last_reg, last_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [ROW_W-1:0]  rmin_reg, rmin_next, rmax_reg, rmax_next;
  logic [COL_W-1:0]  cmin_reg, cmin_next, cmax_reg, cmax_next;
  result_t           res_reg, res_new;
  logic              res_valid_reg, overrun_reg;
  logic [PROF_W-1:0] pick_next;
  logic              pick_any;
  logic              qualify, eof, sched, latch;

  rr_pick #(.NPROF(NPROF)) u_pick (
    .mask (bus.i_en_mask),
    .last (last_reg),
    .next (pick_next),
    .any  (pick_any)
  );

  assign qualify = bus.i_pix_valid && bus.i_hit &&
                   (bus.i_row <= ROW_W'(ROW_MAX)) && (bus.i_col <= COL_W'(COL_MAX));
  assign eof     = bus.i_pix_valid &&
                   (bus.i_row == ROW_W'(ROW_MAX)) && (bus.i_col == COL_W'(COL_MAX));

  always_comb begin
    state_next    = state_reg;
    prof_sel_next = prof_sel_reg;
    last_next     = last_reg;
    count_next    = count_reg;
    rmin_next     = rmin_reg;
    rmax_next     = rmax_reg;
    cmin_next     = cmin_reg;
    cmax_next     = cmax_reg;
    sched         = 1'b0;
    latch         = 1'b0;
    case (state_reg)
      IDLE: sched = bus.i_frame_start && pick_any;
      ACTIVE: begin
        if (bus.i_frame_start) begin
          // Truncated frame: restart on the next profile, no result.
          sched = pick_any;
          if (!pick_any) state_next = IDLE;
        end else begin
          if (qualify) begin
            if (count_reg != '1) count_next = count_reg + CNT_W'(1);
            if (bus.i_row < rmin_reg) rmin_next = bus.i_row;
            if (bus.i_row > rmax_reg) rmax_next = bus.i_row;
            if (bus.i_col < cmin_reg) cmin_next = bus.i_col;
            if (bus.i_col > cmax_reg) cmax_next = bus.i_col;
          end
          if (eof) begin
            latch      = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (sched || (state_reg == ACTIVE && bus.i_frame_start)) begin
      count_next = '0;
      rmin_next  = '1;
      rmax_next  = '0;
      cmin_next  = '1;
      cmax_next  = '0;
    end
    if (sched) begin
      prof_sel_next = pick_next;
      last_next     = pick_next;
      state_next    = ACTIVE;
    end
  end

  // The end-of-frame pixel itself is folded in before the result is captured.
  always_comb begin
    res_new       = '0;
    res_new.prof  = prof_sel_reg;
    res_new.count = count_next;
    res_new.empty = (count_next == '0);
    if (!res_new.empty) begin
      res_new.rmin = rmin_next;
      res_new.rmax = rmax_next;
      res_new.cmin = cmin_next;
      res_new.cmax = cmax_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      prof_sel_reg  <= '0;
      last_reg      <= PROF_W'(NPROF - 1);
      count_reg     <= '0;
      rmin_reg      <= '1;
      rmax_reg      <= '0;
      cmin_reg      <= '1;
      cmax_reg      <= '0;
      res_reg       <= '0;
      res_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      prof_sel_reg <= prof_sel_next;
      last_reg     <= last_next;
      count_reg    <= count_next;
      rmin_reg     <= rmin_next;
      rmax_reg     <= rmax_next;
      cmin_reg     <= cmin_next;
      cmax_reg     <= cmax_next;
      if (latch) begin
        res_reg       <= res_new;
        res_valid_reg <= 1'b1;
        if (res_valid_reg && !bus.i_res_ready) overrun_reg <= 1'b1;
      end else if (res_valid_reg && bus.i_res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.o_prof_sel  = prof_sel_reg;
  assign bus.o_busy      = (state_reg == ACTIVE);
  assign bus.o_res_valid = res_valid_reg;
  assign bus.o_res_prof  = res_reg.prof;
  assign bus.o_res_count = res_reg.count;
  assign bus.o_res_rmin  = res_reg.rmin;
  assign bus.o_res_rmax  = res_reg.rmax;
  assign bus.o_res_cmin  = res_reg.cmin;
  assign bus.o_res_cmax  = res_reg.cmax;
  assign bus.o_res_empty = res_reg.empty;
  assign bus.o_overrun   = overrun_reg;

endmodule

// File: doc/color_profile_sched.md
Name: color_profile_sched

Overview:
- Frame-level scheduler for the HSV color-detect datapath. The datapath's threshold comparator is shared round-robin between up to four color profiles (e.g. red, green); one profile owns the comparator for each whole frame.
- Drives the profile select into the datapath and counts that profile's hit pixels within the active window. It also tracks the hit bounding box.
- Publishes one result per frame through a valid/ready handshake to the downstream tracker/overlay logic.

Parameters:
- NPROF, 4, number of profile slots (2..4)
- ROW_MAX, 477, last valid active row (inclusive)
- COL_MAX, 617, last valid active column (inclusive)
- CNT_W, 19, hit-counter width (holds 478*618 = 295404)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- i_en_mask  in  NPROF  profiles enabled for scheduling; sampled only at frame start
- i_frame_start  in  1  one-cycle pulse, first pixel of a frame
- i_pix_valid  in  1  pixel qualifier for the current row/col/hit
- i_row  in  13  current pixel row
- i_col  in  13  current pixel column
- i_hit  in  1  datapath color-match flag for the current pixel
- o_prof_sel  out  2  profile currently driving the datapath thresholds
- o_busy  out  1  a frame is being accumulated
- o_res_valid  out  1  result available
- i_res_ready  in  1  downstream accepts the result
- o_res_prof  out  2  profile the result belongs to
- o_res_count  out  CNT_W  hit count for the frame
- o_res_rmin, o_res_rmax, o_res_cmin, o_res_cmax  out  13 each  hit bounding box
- o_res_empty  out  1  no hits in the frame; bbox fields are then 0
- o_overrun  out  1  sticky; a frame result was dropped

Behaviour:
- Reset values:
  - Outputs: all zero; o_prof_sel=0.
  - State: IDLE.
  - Accumulators: count=0, rmin=cmin=8191, rmax=cmax=0.
- States:
  - IDLE: wait for i_frame_start.
    - If i_en_mask==0, stay IDLE; o_prof_sel holds.
    - Otherwise select the next enabled profile strictly after the last scheduled one, wrapping at NPROF. The first frame after reset starts the search at slot 0.
    - Set o_prof_sel, clear the accumulators, go to ACTIVE. o_prof_sel changes only on this transition.
  - ACTIVE: o_busy=1.
    - A pixel qualifies when i_pix_valid && i_hit && row<=ROW_MAX && col<=COL_MAX.
    - Each qualifying pixel increments count and updates min/max by compare-and-replace.
    - Count saturates at all-ones.
    - A non-hit pixel, or one outside the window, changes nothing.
    - i_hit is registered with its row/col by the datapath, so accumulation is in the same cycle, with no internal pipeline.
  - End of frame: a qualifying-or-not pixel with row==ROW_MAX && col==COL_MAX && i_pix_valid is accepted, then:
    - Copy the accumulators to the result registers.
    - Set o_res_valid the next cycle.
    - Go to IDLE.
  - i_frame_start while ACTIVE (truncated frame): discard the partial accumulation, do the IDLE scheduling step in the same cycle, and stay ACTIVE with the new profile. No result is produced and o_overrun is not set.
- Result handshake:
  - The result registers are stable while o_res_valid=1.
  - Transfer happens on o_res_valid && i_res_ready. o_res_valid clears the next cycle unless a new result is latched in that same cycle.
  - If a new end-of-frame occurs while o_res_valid=1 and not accepted: overwrite the result with the new frame and set o_overrun (sticky until rst). o_res_valid stays 1.
  - If acceptance and a new end-of-frame happen in the same cycle, the new result is latched, o_res_valid stays 1, and there is no overrun.
- o_res_empty = (count==0). When empty, bbox outputs are forced to 0.
- i_en_mask changes mid-frame have no effect until the next i_frame_start.
- Asynchronous rst mid-frame: immediately return to reset values; the pending result is lost.

Decomposition:
- Shared package color_pkg holds:
  - PROF_W=2
  - ROW_MAX, COL_MAX, ROW_W=COL_W=13
  - state enum {IDLE, ACTIVE}
  - result struct {prof, count, rmin, rmax, cmin, cmax, empty}
- One sub-module: rr_pick. It is a combinational round-robin next-enabled-slot finder taking (mask, last) and returning (next, any).

Test Plan:
- Mask=4'b0011, three full frames, no hits → results prof 0, 1, 0; count=0, empty=1, bbox 0.
- Mask=4'b0101, hits at (10,20), (100,5), (477,617), plus one hit at (478,0) → count=3, rmin=10, rmax=477, cmin=5, cmax=617. The out-of-window hit is ignored.
- Keep i_res_ready=0 across two frames → o_overrun=1 and the result holds the second frame. Then assert ready → o_res_valid drops one cycle later.
- i_frame_start at row 200 of a mask=4'b1111 frame on prof 1 → no result for prof 1; o_prof_sel=2 and the accumulators are cleared.
- Assert rst mid-ACTIVE with 50 hits counted → all outputs 0 immediately. The next frame schedules from slot 0.
- Mask=0 at i_frame_start → stays IDLE, o_busy=0, no result. Then mask=4'b1000 → next frame uses prof 3.
